// File: rtl/fifo_level.sv
// rtl/fifo_level.sv - single-clock FWFT FIFO with occupancy, almost flags, flush and sticky errors
// Status outputs come only from registered pointers and flags, so ready never depends on read_i/write_i.
module fifo_level #(
    parameter int DATA_BITS          = 8,
    parameter int DEPTH_BITS         = 2,
    parameter int ALMOST_FULL_LEVEL  = (1 << DEPTH_BITS) - 1,
    parameter int ALMOST_EMPTY_LEVEL = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush_i,
    input  logic                  write_i,
    input  logic [DATA_BITS-1:0]  write_data_i,
    output logic                  write_ready_o,
    input  logic                  read_i,
    output logic [DATA_BITS-1:0]  read_data_o,
    output logic                  read_ready_o,
    output logic [DEPTH_BITS:0]   level_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic                  overflow_o,
    output logic                  underflow_o,
    input  logic                  clear_errors_i
);

    localparam int                DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] LP_AF_LEVEL = (DEPTH_BITS + 1)'(ALMOST_FULL_LEVEL);
    localparam logic [DEPTH_BITS:0] LP_AE_LEVEL = (DEPTH_BITS + 1)'(ALMOST_EMPTY_LEVEL);
    localparam logic [DEPTH_BITS:0] LP_PTR_ONE  = (DEPTH_BITS + 1)'(1);

    logic [DATA_BITS-1:0]  r_mem [DEPTH];
    logic [DEPTH_BITS:0]   r_wr_ptr;
    logic [DEPTH_BITS:0]   r_rd_ptr;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_wr_accept;
    logic                  w_rd_accept;
    logic                  w_ovf_set;
    logic                  w_unf_set;
    logic [DEPTH_BITS:0]   w_level;

    // Extra pointer MSB separates full (MSBs differ) from empty (identical).
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[DEPTH_BITS] != r_rd_ptr[DEPTH_BITS]) &&
                     (r_wr_ptr[DEPTH_BITS-1:0] == r_rd_ptr[DEPTH_BITS-1:0]);
    assign w_level = r_wr_ptr - r_rd_ptr;

    assign w_wr_accept = write_i & ~w_full  & ~flush_i;
    assign w_rd_accept = read_i  & ~w_empty & ~flush_i;
    assign w_ovf_set   = write_i & w_full   & ~flush_i;
    assign w_unf_set   = read_i  & w_empty  & ~flush_i;

    always_ff @(posedge clock) begin
        if (w_wr_accept) begin
            r_mem[r_wr_ptr[DEPTH_BITS-1:0]] <= write_data_i;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
            end
            if (flush_i) begin
                r_rd_ptr <= r_wr_ptr;
            end else if (w_rd_accept) begin
                r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
            end
        end
    end

    // A new error event in the same cycle as clear_errors_i keeps the flag set.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= w_ovf_set | (r_overflow  & ~clear_errors_i);
            r_underflow <= w_unf_set | (r_underflow & ~clear_errors_i);
        end
    end

    assign read_data_o    = r_mem[r_rd_ptr[DEPTH_BITS-1:0]];
    assign read_ready_o   = ~w_empty;
    assign write_ready_o  = ~w_full;
    assign level_o        = w_level;
    assign almost_full_o  = (w_level >= LP_AF_LEVEL);
    assign almost_empty_o = (w_level <= LP_AE_LEVEL);
    assign overflow_o     = r_overflow;
    assign underflow_o    = r_underflow;

endmodule
